// File: rtl/adder_pkg.sv
// Shared types for the pipelined adder: operation select and the per-stage control record.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } add_op_e;

  // carry is the carry out of the slice this stage has just added.
  typedef struct packed {
    logic    valid;
    add_op_e op;
    logic    carry;
  } stage_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit adder slice; c_msb is the carry into the slice MSB, used for overflow.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum    = w_full[W-1:0];
  assign cout   = w_full[W];
  assign c_msb  = a[W-1] ^ b[W-1] ^ w_full[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract, one WIDTH/STAGES-bit slice per stage, carry registered between stages.
// Define PIPE_ADDER_FLAGS_EN to compute out_cout/out_ovf/out_zero; otherwise they are tied to 0.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  add_op_e          in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  stage_t           r_stage [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];

  logic [STAGES:0]               w_ready;
  logic [STAGES-1:0]             w_vin;
  logic [STAGES-1:0]             w_cin;
  logic [STAGES-1:0]             w_cout;
  logic [STAGES-1:0]             w_cmsb;
  add_op_e                       w_op_in  [STAGES];
  logic [WIDTH-1:0]              w_a_in   [STAGES];
  logic [WIDTH-1:0]              w_b_in   [STAGES];
  logic [WIDTH-1:0]              w_sum_in [STAGES];
  logic [WIDTH-1:0]              w_sum_nx [STAGES];
  logic [STAGES-1:0][SLICE-1:0]  w_slice_sum;
  logic                          w_unused;

  // Handshake: a transfer happens iff valid && ready in the same cycle; a stage
  // can load when it is empty or its successor is loading this cycle.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = !r_stage[k].valid || w_ready[k+1];
    end
  end

  assign in_ready = w_ready[0];

  always_comb begin
    w_vin[0]    = in_valid;
    w_op_in[0]  = in_op;
    w_cin[0]    = (in_op == OP_SUB) ? 1'b1 : in_cin;
    w_a_in[0]   = in_a;
    w_b_in[0]   = in_b;
    w_sum_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_vin[k]    = r_stage[k-1].valid;
      w_op_in[k]  = r_stage[k-1].op;
      w_cin[k]    = r_stage[k-1].carry;
      w_a_in[k]   = r_a[k-1];
      w_b_in[k]   = r_b[k-1];
      w_sum_in[k] = r_sum[k-1];
    end
  end

  for (genvar gk = 0; gk < STAGES; gk++) begin : g_stage
    logic [SLICE-1:0] w_b_eff;

    // B travels uninverted; each stage inverts its own slice for subtraction.
    assign w_b_eff = (w_op_in[gk] == OP_SUB) ? ~w_b_in[gk][gk*SLICE +: SLICE]
                                             :  w_b_in[gk][gk*SLICE +: SLICE];

    adder_slice #(.W(SLICE)) u_slice (
      .a     (w_a_in[gk][gk*SLICE +: SLICE]),
      .b     (w_b_eff),
      .cin   (w_cin[gk]),
      .sum   (w_slice_sum[gk]),
      .cout  (w_cout[gk]),
      .c_msb (w_cmsb[gk])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_sum_nx[k]                    = w_sum_in[k];
      w_sum_nx[k][k*SLICE +: SLICE]  = w_slice_sum[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_stage[k].valid <= w_vin[k];
          if (w_vin[k]) begin
            r_stage[k].op    <= w_op_in[k];
            r_stage[k].carry <= w_cout[k];
            r_a[k]           <= w_a_in[k];
            r_b[k]           <= w_b_in[k];
            r_sum[k]         <= w_sum_nx[k];
          end
        end
      end
    end
  end

  assign out_valid = r_stage[LAST].valid;
  assign out_sum   = r_sum[LAST];

`ifdef PIPE_ADDER_FLAGS_EN
  logic r_ovf;
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_ready[LAST] && w_vin[LAST]) begin
      r_ovf  <= w_cmsb[LAST] ^ w_cout[LAST];
      r_zero <= (w_sum_nx[LAST] == '0);
    end
  end

  assign out_cout = r_stage[LAST].carry;
  assign out_ovf  = r_ovf;
  assign out_zero = r_zero;
`else
  assign out_cout = 1'b0;
  assign out_ovf  = 1'b0;
  assign out_zero = 1'b0;
`endif

  // Operand copies in the last stage and per-slice MSB carries below the top have no consumer.
  assign w_unused = ^{r_a[LAST], r_b[LAST], r_stage[LAST], w_cmsb};

endmodule
